butterfly_serial_packer: RTL and testbench
==========================================

// Module: butterfly_serial_packer
// PURPOSE
// - Output-side counterpart of the butterfly_processor serial port (dn_serial_*_A/B): accepts one fp16 element per BE lane per beat.
// - Packs PACK consecutive elements per lane into one wide beat, counts a frame of `length` elements, flags the final beat, pulses done.
// - Sits between butterfly_processor serial output and the AXI write-back path.
// PARAMETERS
// - DATA_WIDTH       16  bits per fp16 element
// - BE_PARALLELISM   32  butterfly-engine lanes per serial beat
// - OUTPUT_AXI_CHNL  8   width of per-channel valid vector from the processor
// - PACK             4   elements per lane per output beat (power of 2, >=2)
// - LEN_W            16  width of length field
// PORTS
// - clk      in   1                            clock, all logic on posedge
// - rst      in   1                            synchronous, active-high reset
// - length   in   LEN_W                        frame length in elements per lane; sampled on accepted start
// - start    in   1                            frame start pulse
// - up_vld   in   OUTPUT_AXI_CHNL              per-channel valid from processor serial port
// - up_dat   in   DATA_WIDTH*BE_PARALLELISM    lane l at [DATA_WIDTH*l +: DATA_WIDTH]
// - up_rdy   out  1                            ready to processor
// - dn_vld   out  1                            packed beat valid
// - dn_dat   out  DATA_WIDTH*BE_PARALLELISM*PACK  lane l slot s at [DATA_WIDTH*(l*PACK+s) +: DATA_WIDTH]
// - dn_last  out  1                            final beat of frame, qualified by dn_vld
// - dn_rdy   in   1                            downstream ready
// - busy     out  1                            high in COLLECT or DRAIN
// - done     out  1                            one-cycle pulse after last beat handshake
// - err_cfg  out  1                            sticky: start rejected (length==0 or length%PACK!=0)
// - err_part out  1                            sticky: up_vld nonzero but not all-ones
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, slot/element counters 0, assembly and output registers cleared. Reset mid-frame discards partial data.
// - Input beat accepted iff &up_vld && up_rdy. Partial up_vld (nonzero, not all ones) is never accepted. It sets err_part; cleared only by rst.
// - FSM IDLE: start with valid length -> COLLECT. Latch length, zero counters. Invalid length -> set err_cfg, stay IDLE. start in any other state is ignored.
// - FSM COLLECT: accepted element goes to slot `slot` of each lane's assembly reg. slot increments and wraps at PACK.
//   - On slot==PACK-1: assembly plus the incoming element move into the output reg in the same cycle. dn_vld rises the next cycle (latency 1 from completing element).
//   - Element count reaching length marks that beat dn_last=1 and moves the FSM -> DRAIN.
// - up_rdy = (state==COLLECT) && (slot!=PACK-1 || !dn_vld || dn_rdy). The processor stalls only when a finished group cannot enter the output reg.
// - Output reg: dn_dat/dn_last hold stable while dn_vld && !dn_rdy. dn_vld drops after handshake unless reloaded in the same cycle.
// - FSM DRAIN: wait for handshake of the dn_last beat. Next cycle done=1 for one cycle and FSM -> IDLE. busy low in IDLE.
// - Simultaneous events:
//   - output handshake and a new group load in one cycle: the new group wins, dn_vld stays 1.
//   - rst with any input: rst wins.
// - Element counter is LEN_W wide. Frames up to 2^LEN_W-PACK elements per lane; no wrap inside a frame.
// STRUCTURE
// - butterfly_pkg: DATA_WIDTH/BE_PARALLELISM/OUTPUT_AXI_CHNL defaults, fp16_t typedef, packer_state_e {IDLE,COLLECT,DRAIN}.
// - Sub-module serial_lane_packer (one per lane, generate loop): PACK-entry assembly reg written at slot index, emits PACK*DATA_WIDTH word.
// - Top holds FSM, counters, output register, handshake logic.
// TESTING
// - length=256, start; beat i drives every lane with fp16(i), dn_rdy=1 -> 64 beats. Beat k lane l slot s = fp16(4k+s); dn_last only on beat 63; done pulses 1 cycle after.
// - Same frame with dn_rdy=0 for 10 cycles at beat 5 -> up_rdy low once next group completes; dn_dat stable; all 256 elements delivered in order, none lost or duplicated.
// - length=6 start -> err_cfg=1, busy stays 0, no dn_vld. Then length=8 start -> 2 beats, done.
// - During COLLECT drive up_vld=8'h0F for 3 cycles -> no acceptance, counters frozen, err_part=1 and sticky. Then 8'hFF resumes correctly.
// - rst asserted after 10 elements -> next cycle all outputs 0, FSM IDLE. New start of length=4 -> beat holds elements 0..3 only.
// - start pulsed mid-frame -> ignored, length unchanged, frame completes with original 64 beats.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared defaults, element type and packer FSM states for the butterfly
// serial output path.
package butterfly_pkg;

    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_BE_PARALLELISM  = 32;
    localparam int DEF_OUTPUT_AXI_CHNL = 8;
    localparam int DEF_PACK            = 4;
    localparam int DEF_LEN_W           = 16;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } packer_state_e;

endpackage

// File: rtl/serial_lane_packer.sv
// One lane's assembly register: collects PACK serial elements and presents
// them as a single wide word, with the incoming element bypassed into its slot.
module serial_lane_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int PACK       = 4,
    localparam int SLOT_W    = $clog2(PACK)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [SLOT_W-1:0]          i_slot,
    input  logic [DATA_WIDTH-1:0]      i_din,
    output logic [DATA_WIDTH*PACK-1:0] o_word
);

    logic [DATA_WIDTH-1:0] r_asm [PACK];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < PACK; s++) begin
                r_asm[s] <= '0;
            end
        end else if (i_we) begin
            r_asm[i_slot] <= i_din;
        end
    end

    // Bypass lets the group's final element reach the output register in
    // the same cycle it arrives.
    always_comb begin
        o_word = '0;
        for (int s = 0; s < PACK; s++) begin
            if (i_we && (i_slot == SLOT_W'(s))) begin
                o_word[DATA_WIDTH*s +: DATA_WIDTH] = i_din;
            end else begin
                o_word[DATA_WIDTH*s +: DATA_WIDTH] = r_asm[s];
            end
        end
    end

endmodule

// File: rtl/butterfly_serial_packer.sv
// Packs PACK consecutive serial elements per butterfly lane into one wide
// output beat, framing `length` elements with dn_last and a done pulse.
module butterfly_serial_packer
    import butterfly_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BE_PARALLELISM  = DEF_BE_PARALLELISM,
    parameter int OUTPUT_AXI_CHNL = DEF_OUTPUT_AXI_CHNL,
    parameter int PACK            = DEF_PACK,
    parameter int LEN_W           = DEF_LEN_W
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [LEN_W-1:0]                         i_length,
    input  logic                                     i_start,
    input  logic [OUTPUT_AXI_CHNL-1:0]               i_up_vld,
    input  logic [DATA_WIDTH*BE_PARALLELISM-1:0]     i_up_dat,
    output logic                                     o_up_rdy,
    output logic                                     o_dn_vld,
    output logic [DATA_WIDTH*BE_PARALLELISM*PACK-1:0] o_dn_dat,
    output logic                                     o_dn_last,
    input  logic                                     i_dn_rdy,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err_cfg,
    output logic                                     o_err_part
);

    localparam int SLOT_W = $clog2(PACK);
    localparam int BEAT_W = DATA_WIDTH * BE_PARALLELISM * PACK;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK - 1);

    packer_state_e r_state, w_next_state;

    logic [SLOT_W-1:0] r_slot;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_length;
    logic              r_dn_vld;
    logic              r_dn_last;
    logic [BEAT_W-1:0] r_dn_dat;
    logic              r_done;
    logic              r_err_cfg;
    logic              r_err_part;

    logic [BEAT_W-1:0] w_packed;
    logic              w_len_ok;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_group_done;
    logic              w_final_elem;
    logic              w_dn_hs;

    assign w_len_ok     = (i_length != '0) && (i_length[SLOT_W-1:0] == '0);
    assign w_start_ok   = (r_state == IDLE) && i_start && w_len_ok;
    // Only a completing group needs room in the output register.
    assign o_up_rdy     = (r_state == COLLECT) &&
                          ((r_slot != LAST_SLOT) || !r_dn_vld || i_dn_rdy);
    assign w_accept     = (&i_up_vld) && o_up_rdy;
    assign w_group_done = w_accept && (r_slot == LAST_SLOT);
    assign w_final_elem = w_accept && ((r_count + LEN_W'(1)) == r_length);
    assign w_dn_hs      = r_dn_vld && i_dn_rdy;

    for (genvar l = 0; l < BE_PARALLELISM; l++) begin : g_lane
        serial_lane_packer #(
            .DATA_WIDTH (DATA_WIDTH),
            .PACK       (PACK)
        ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_we   (w_accept),
            .i_slot (r_slot),
            .i_din  (i_up_dat[DATA_WIDTH*l +: DATA_WIDTH]),
            .o_word (w_packed[DATA_WIDTH*PACK*l +: DATA_WIDTH*PACK])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_busy       = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = COLLECT;
            COLLECT: if (w_final_elem) w_next_state = DRAIN;
            DRAIN:   if (w_dn_hs && r_dn_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot   <= '0;
            r_count  <= '0;
            r_length <= '0;
        end else if (w_start_ok) begin
            r_slot   <= '0;
            r_count  <= '0;
            r_length <= i_length;
        end else if (w_accept) begin
            r_slot   <= r_slot + SLOT_W'(1);
            r_count  <= r_count + LEN_W'(1);
        end
    end

    // A new group load takes priority over clearing valid on handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dn_vld  <= 1'b0;
            r_dn_last <= 1'b0;
            r_dn_dat  <= '0;
        end else if (w_group_done) begin
            r_dn_vld  <= 1'b1;
            r_dn_last <= w_final_elem;
            r_dn_dat  <= w_packed;
        end else if (w_dn_hs) begin
            r_dn_vld  <= 1'b0;
            r_dn_last <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done     <= 1'b0;
            r_err_cfg  <= 1'b0;
            r_err_part <= 1'b0;
        end else begin
            r_done     <= (r_state == DRAIN) && w_dn_hs && r_dn_last;
            r_err_cfg  <= r_err_cfg | ((r_state == IDLE) && i_start && !w_len_ok);
            r_err_part <= r_err_part | ((|i_up_vld) && !(&i_up_vld));
        end
    end

    assign o_dn_vld   = r_dn_vld;
    assign o_dn_last  = r_dn_last;
    assign o_dn_dat   = r_dn_dat;
    assign o_done     = r_done;
    assign o_err_cfg  = r_err_cfg;
    assign o_err_part = r_err_part;

endmodule

// File: tb/tb_butterfly_serial_packer.sv
// Directed self-checking bench for butterfly_serial_packer: full frames,
// back-pressure, config and partial-valid errors, reset mid-frame.
module tb_butterfly_serial_packer;
    import butterfly_pkg::*;

    localparam int DW     = 16;
    localparam int BP     = 32;
    localparam int CH     = 8;
    localparam int PK     = 4;
    localparam int LW     = 16;
    localparam int BEAT_W = DW * BP * PK;

    logic              clk = 1'b0;
    logic              rst;
    logic [LW-1:0]     i_length;
    logic              i_start;
    logic [CH-1:0]     i_up_vld;
    logic [DW*BP-1:0]  i_up_dat;
    logic              o_up_rdy;
    logic              o_dn_vld;
    logic [BEAT_W-1:0] o_dn_dat;
    logic              o_dn_last;
    logic              i_dn_rdy;
    logic              o_busy;
    logic              o_done;
    logic              o_err_cfg;
    logic              o_err_part;

    int checks = 0;
    int errors = 0;

    logic [BEAT_W-1:0] beatQ[$];
    bit                lastQ[$];
    int                cycleNo = 0;
    int                doneCnt = 0;
    int                doneCyc = 0;
    int                lastHsCyc = -10;
    int                vldSeen = 0;
    int                stableViol = 0;
    bit                prevStall = 0;
    logic [BEAT_W-1:0] prevDat;
    logic              prevLast;
    bit                upRdyLowSeen = 0;
    int                usedCyc;

    always #5 clk = ~clk;

    butterfly_serial_packer dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_length   (i_length),
        .i_start    (i_start),
        .i_up_vld   (i_up_vld),
        .i_up_dat   (i_up_dat),
        .o_up_rdy   (o_up_rdy),
        .o_dn_vld   (o_dn_vld),
        .o_dn_dat   (o_dn_dat),
        .o_dn_last  (o_dn_last),
        .i_dn_rdy   (i_dn_rdy),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err_cfg  (o_err_cfg),
        .o_err_part (o_err_part)
    );

    // Scoreboard capture on the falling edge: handshakes, done pulses and
    // stability of a stalled output beat.
    always @(negedge clk) begin
        cycleNo++;
        if (prevStall) begin
            if (!o_dn_vld || (o_dn_dat !== prevDat) || (o_dn_last !== prevLast)) begin
                stableViol++;
            end
        end
        prevStall = o_dn_vld && !i_dn_rdy;
        prevDat   = o_dn_dat;
        prevLast  = o_dn_last;
        if (o_dn_vld) vldSeen++;
        if (o_dn_vld && i_dn_rdy) begin
            beatQ.push_back(o_dn_dat);
            lastQ.push_back(o_dn_last);
            if (o_dn_last) lastHsCyc = cycleNo;
        end
        if (o_done) begin
            doneCnt++;
            doneCyc = cycleNo;
        end
    end

    function automatic fp16_t fp16Of(input int i);
        int e;
        int mant;
        if (i == 0) return 16'h0000;
        e = 0;
        while ((i >> (e + 1)) != 0) e++;
        mant = (i << (10 - e)) & 'h3FF;
        return {1'b0, 5'(e + 15), 10'(mant)};
    endfunction

    function automatic fp16_t elemVal(input int i, input int l, input bit mix);
        fp16_t v;
        v = fp16Of(i);
        if (mix) v = v ^ 16'(l);
        return v;
    endfunction

    function automatic logic [63:0] expLane(input int k, input int l, input bit mix);
        logic [63:0] r;
        r = '0;
        for (int s = 0; s < PK; s++) begin
            r[16*s +: 16] = elemVal(PK*k + s, l, mix);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearSb();
        beatQ.delete();
        lastQ.delete();
        doneCnt      = 0;
        vldSeen      = 0;
        stableViol   = 0;
        upRdyLowSeen = 0;
        lastHsCyc    = -10;
    endtask

    task automatic startFrame(input int len);
        i_length = LW'(len);
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
    endtask

    // Streams n elements; optional back-pressure, partial-valid window and
    // a stray start pulse, each triggered at a given point of the frame.
    task automatic applyStimulus(input int n, input bit mix, input int stallBeat,
                                 input int partAt, input int startAt, output int cycles);
        int idx = 0;
        int stallLeft = 0;
        int partLeft = 0;
        bit stallUsed = 0;
        bit partUsed = 0;
        bit acc;
        int limit = n * 4 + 100;
        cycles = 0;
        while (idx < n && cycles < limit) begin
            if (stallBeat >= 0 && !stallUsed && beatQ.size() == stallBeat && o_dn_vld) begin
                stallUsed = 1;
                stallLeft = 10;
            end
            i_dn_rdy = (stallLeft == 0);
            if (stallLeft > 0) stallLeft--;
            if (partAt >= 0 && !partUsed && idx == partAt) begin
                partUsed = 1;
                partLeft = 3;
            end
            i_up_vld = (partLeft > 0) ? 8'h0F : 8'hFF;
            if (partLeft > 0) partLeft--;
            if (idx == startAt) begin
                i_start  = 1'b1;
                i_length = LW'(6);
            end else begin
                i_start  = 1'b0;
            end
            for (int l = 0; l < BP; l++) begin
                i_up_dat[DW*l +: DW] = elemVal(idx, l, mix);
            end
            @(negedge clk);
            acc = (i_up_vld == 8'hFF) && o_up_rdy;
            if (!i_dn_rdy && !o_up_rdy) upRdyLowSeen = 1;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cycles++;
        end
        if (idx < n) checkOutput("streamTimeout", 64'(idx), 64'(n));
        i_up_vld = '0;
        i_start  = 1'b0;
        i_dn_rdy = 1'b1;
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (doneCnt == 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput({tag, "_doneSeen"}, 64'(doneCnt > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_donePulses"}, 64'(doneCnt), 64'd1);
        checkOutput({tag, "_doneTiming"}, 64'(doneCyc - lastHsCyc), 64'd1);
        checkOutput({tag, "_busyIdle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic checkFrame(input string tag, input int nBeats, input bit mix);
        logic [BEAT_W-1:0] b;
        int m;
        checkOutput({tag, "_beatCount"}, 64'(beatQ.size()), 64'(nBeats));
        m = (beatQ.size() < nBeats) ? beatQ.size() : nBeats;
        for (int k = 0; k < m; k++) begin
            b = beatQ[k];
            for (int l = 0; l < BP; l++) begin
                checkOutput($sformatf("%s_beat%0d_lane%0d", tag, k, l), b[64*l +: 64], expLane(k, l, mix));
            end
            checkOutput($sformatf("%s_last%0d", tag, k), 64'(lastQ[k]), 64'(k == nBeats - 1));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_upRdy"},   64'(o_up_rdy),   64'd0);
        checkOutput({tag, "_dnVld"},   64'(o_dn_vld),   64'd0);
        checkOutput({tag, "_dnLast"},  64'(o_dn_last),  64'd0);
        checkOutput({tag, "_dnDat"},   o_dn_dat[63:0],  64'd0);
        checkOutput({tag, "_busy"},    64'(o_busy),     64'd0);
        checkOutput({tag, "_done"},    64'(o_done),     64'd0);
        checkOutput({tag, "_errCfg"},  64'(o_err_cfg),  64'd0);
        checkOutput({tag, "_errPart"}, 64'(o_err_part), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        i_length = '0;
        i_start  = 1'b0;
        i_up_vld = '0;
        i_up_dat = '0;
        i_dn_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] frame of 256 elements, no back-pressure");
        clearSb();
        startFrame(256);
        checkOutput("A_busyAfterStart", 64'(o_busy), 64'd1);
        applyStimulus(256, 1'b0, -1, -1, -1, usedCyc);
        checkOutput("A_streamCycles", 64'(usedCyc), 64'd256);
        checkOutput("A_finalVld", 64'(o_dn_vld), 64'd1);
        checkOutput("A_finalLast", 64'(o_dn_last), 64'd1);
        waitDone("A");
        checkFrame("A", 64, 1'b0);

        $display("[TB] invalid length 6, then length 8");
        clearSb();
        startFrame(6);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("cfg_errCfg", 64'(o_err_cfg), 64'd1);
        checkOutput("cfg_busy", 64'(o_busy), 64'd0);
        checkOutput("cfg_upRdy", 64'(o_up_rdy), 64'd0);
        checkOutput("cfg_noVld", 64'(vldSeen), 64'd0);
        startFrame(8);
        applyStimulus(8, 1'b1, -1, -1, -1, usedCyc);
        waitDone("L8");
        checkFrame("L8", 2, 1'b1);
        checkOutput("L8_errCfgSticky", 64'(o_err_cfg), 64'd1);

        $display("[TB] frame with stall, partial valid and stray start");
        clearSb();
        startFrame(256);
        applyStimulus(256, 1'b1, 5, 60, 100, usedCyc);
        waitDone("B");
        checkFrame("B", 64, 1'b1);
        checkOutput("B_stable", 64'(stableViol), 64'd0);
        checkOutput("B_upRdyLow", 64'(upRdyLowSeen), 64'd1);
        checkOutput("B_errPart", 64'(o_err_part), 64'd1);
        checkOutput("B_errCfgUnchanged", 64'(o_err_cfg), 64'd1);

        $display("[TB] reset after 10 elements, then length 4");
        clearSb();
        startFrame(256);
        applyStimulus(10, 1'b0, -1, -1, -1, usedCyc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midRst");
        rst = 1'b0;
        clearSb();
        startFrame(4);
        applyStimulus(4, 1'b1, -1, -1, -1, usedCyc);
        waitDone("L4");
        checkFrame("L4", 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
